imem_loader: RTL and testbench

Boot-time instruction-memory loader that sits directly upstream of the single-cycle MIPS core. It accepts a byte stream with a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into the program memory. While loading it holds the core in reset, and it releases the core once the image is complete. An optional trailing XOR checksum gates the release.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Purpose : boot loader; streams a big-endian image into program memory, then releases the core.
// Latency : a word is written one cycle after its 4th byte; the core is released 2 edges after the final byte.
// Backpress: o_ready is high only while header/data/checksum bytes are expected; it is low in FINISH, DONE and ERROR.
//
// Ports:
//   i_clk, i_rst_n (async, active-low), i_restart (sync abort/reload)
//   i_valid/i_data/o_ready : byte stream in, valid/ready handshake
//   o_we/o_waddr/o_wdata   : program-memory write port (one strobe per word)
//   o_cpu_rst_n/o_done/o_error : core reset and load status (all registered)
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR byte
// that covers the header and data bytes. The loader releases the core only when that byte matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_restart,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_ready,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [31:0]           o_wdata,
    output logic                  o_cpu_rst_n,
    output logic                  o_done,
    output logic                  o_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK, S_FINISH, S_DONE, S_ERROR
    } state_t;
    // After the last word (or an empty image), the checksum byte is still outstanding.
    localparam state_t S_TAIL = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_FINISH, S_DONE, S_ERROR
    } state_t;
    localparam state_t S_TAIL = S_FINISH;
`endif

    // The header is 16 bits. It is held 17 bits wide so that a full-capacity image (2^ADDR_WIDTH) compares exactly.
    localparam logic [16:0]         CAPACITY = 17'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE      = 1;

    state_t                state, state_next;
    logic [7:0]            n_hi;
    logic [ADDR_WIDTH:0]   n_words;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [ADDR_WIDTH:0]   word_idx_inc;
    logic [1:0]            byte_cnt;
    logic [23:0]           asm_reg;     // the first three bytes of a word; the 4th byte goes straight to o_wdata
    logic [16:0]           hdr_n;
    logic                  xfer;
    logic                  last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xor_acc;
`endif

    assign xfer         = i_valid && o_ready;
    assign hdr_n        = {1'b0, n_hi, i_data};
    assign word_idx_inc = word_idx + ONE;
    assign last_word    = (word_idx_inc == n_words);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_CNT_HI;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A restart has priority over any byte offered in the same cycle.
    always_comb begin
        state_next = state;
        if (i_restart) begin
            state_next = S_CNT_HI;
        end else begin
            case (state)
                S_CNT_HI: if (xfer) state_next = S_CNT_LO;
                S_CNT_LO: begin
                    if (xfer) begin
                        if (hdr_n > CAPACITY) begin
                            state_next = S_ERROR;
                        end else if (hdr_n == 17'd0) begin
                            state_next = S_TAIL;
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end
                S_DATA: if (xfer && byte_cnt == 2'd3 && last_word) state_next = S_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: if (xfer) state_next = (i_data == xor_acc) ? S_FINISH : S_ERROR;
`endif
                S_FINISH: state_next = S_DONE;
                S_DONE:   state_next = S_DONE;
                S_ERROR:  state_next = S_ERROR;
                default:  state_next = S_CNT_HI;
            endcase
        end
    end

    // Output logic: ready is a pure decode of the state and does not depend on i_valid.
    always_comb begin
        o_ready = 1'b0;
        case (state)
            S_CNT_HI, S_CNT_LO, S_DATA: o_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:                    o_ready = 1'b1;
`endif
            default:                    o_ready = 1'b0;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            n_hi        <= '0;
            n_words     <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            asm_reg     <= '0;
            o_we        <= 1'b0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_cpu_rst_n <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else if (i_restart) begin
            // Abort everything, including a partially assembled word, so no partial write can occur.
            n_hi        <= '0;
            n_words     <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            asm_reg     <= '0;
            o_we        <= 1'b0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_cpu_rst_n <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_we <= 1'b0;
            case (state)
                S_CNT_HI: if (xfer) n_hi <= i_data;
                // An oversize count is truncated here, but it never matters because the loader goes to ERROR.
                S_CNT_LO: if (xfer) n_words <= hdr_n[ADDR_WIDTH:0];
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_reg  <= {asm_reg[15:0], i_data};
                        if (byte_cnt == 2'd3) begin
                            o_we     <= 1'b1;
                            o_wdata  <= {asm_reg, i_data};
                            o_waddr  <= word_idx[ADDR_WIDTH-1:0];
                            word_idx <= word_idx_inc;
                        end
                    end
                end
                default: ;
            endcase
            // The status outputs are registered from the next state, so they change on the edge that enters DONE or ERROR.
            o_cpu_rst_n <= (state_next == S_DONE);
            o_done      <= (state_next == S_DONE);
            o_error     <= (state_next == S_ERROR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // The running XOR covers both header bytes and all data bytes, but not the checksum byte itself.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xor_acc <= '0;
        end else if (i_restart) begin
            xor_acc <= '0;
        end else if (xfer && (state == S_CNT_HI || state == S_CNT_LO || state == S_DATA)) begin
            xor_acc <= xor_acc ^ i_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Purpose : randomized scoreboard bench for imem_loader (ADDR_WIDTH=8).
// Latency : checks the write strobe per word and the release 2 edges after the final byte.
// Backpress: waits on o_ready with a bounded budget before each byte it offers.
module tb_imem_loader;
    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_restart;
    logic          i_valid;
    logic [7:0]    i_data;
    logic          o_ready;
    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [31:0]   o_wdata;
    logic          o_cpu_rst_n;
    logic          o_done;
    logic          o_error;

    always #5 i_clk = ~i_clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_restart   (i_restart),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    wr_t         exp_q[$];
    logic [31:0] img [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the next expected (address, word).
    always @(negedge i_clk) begin
        wr_t e;
        if (i_rst_n && o_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h, expected no write", o_waddr, o_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 32'(o_waddr), 32'(e.addr));
                chk("wdata", o_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = b;
        while (!o_ready && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got o_ready 0 expected 1");
        end
        @(posedge i_clk);
    endtask

    // Restart while offering a byte. That byte must be discarded.
    task automatic pulse_restart();
        @(negedge i_clk);
        i_restart = 1'b1;
        i_valid   = 1'b1;
        i_data    = 8'($urandom);
        @(negedge i_clk);
        i_restart = 1'b0;
        i_valid   = 1'b0;
        chk("rs_ready", 32'(o_ready), 32'd1);
        chk("rs_done", 32'(o_done), 32'd0);
        chk("rs_error", 32'(o_error), 32'd0);
        chk("rs_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
        chk("rs_we", 32'(o_we), 32'd0);
    endtask

    // Reference: an image of n words from img[], plus an optional checksum byte.
    // abort_at >= 0 stops before byte abort_at, then applies either the async reset or a restart.
    task automatic run_image(input int n, input bit gapped, input bit bad_ck,
                             input int abort_at, input bit abort_rst);
        logic [7:0]  bs[$];
        logic [15:0] n16;
        logic [7:0]  ck;
        bit          oversize;
        bit          ok;
        int          limit;
        n16      = n[15:0];
        oversize = (n > (1 << AW));
        ok       = !oversize;
        bs.push_back(n16[15:8]);
        bs.push_back(n16[7:0]);
        if (!oversize) begin
            for (int i = 0; i < n; i++) begin
                for (int b = 3; b >= 0; b--) bs.push_back(img[i][8*b +: 8]);
                if (abort_at < 0 || 6 + 4 * i <= abort_at) exp_q.push_back('{addr: AW'(i), data: img[i]});
            end
        end
        ck = 8'h00;
        foreach (bs[k]) ck ^= bs[k];
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!oversize) begin
            bs.push_back(bad_ck ? (ck ^ 8'($urandom_range(255, 1))) : ck);
            ok = !bad_ck;
        end
`else
        if (bad_ck) ck = ~ck;
`endif
        limit = (abort_at >= 0) ? abort_at : bs.size();
        for (int i = 0; i < limit; i++) begin
            if (gapped && $urandom_range(1) == 1) begin
                @(negedge i_clk);
                i_valid = 1'b0;
                i_data  = 8'($urandom);
            end
            send_byte(bs[i]);
        end
        if (abort_at >= 0) begin
            if (abort_rst) begin
                #2 i_rst_n = 1'b0;
                i_valid = 1'b0;
                #1;
                chk("ar_we", 32'(o_we), 32'd0);
                chk("ar_waddr", 32'(o_waddr), 32'd0);
                chk("ar_wdata", o_wdata, 32'd0);
                chk("ar_done", 32'(o_done), 32'd0);
                chk("ar_error", 32'(o_error), 32'd0);
                chk("ar_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
                chk("ar_ready", 32'(o_ready), 32'd1);
                @(negedge i_clk);
                i_rst_n = 1'b1;
            end else begin
                pulse_restart();
            end
            chk("abort_pending_writes", exp_q.size(), 32'd0);
            exp_q.delete();
            return;
        end
        // Edge k has just transferred the final byte.
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = 8'h00;
        chk("k_ready", 32'(o_ready), 32'd0);
        chk("k_done", 32'(o_done), 32'd0);
        chk("k_error", 32'(o_error), 32'(!ok));
        chk("k_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
        @(negedge i_clk);
        chk("k1_done", 32'(o_done), 32'(ok));
        chk("k1_error", 32'(o_error), 32'(!ok));
        chk("k1_cpu_rst_n", 32'(o_cpu_rst_n), 32'(ok));
        chk("k1_ready", 32'(o_ready), 32'd0);
        chk("pending_writes", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n   = 1'b0;
        i_restart = 1'b0;
        i_valid   = 1'b0;
        i_data    = 8'h00;
        #12;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_waddr", 32'(o_waddr), 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_error", 32'(o_error), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Two-word image, with back-to-back bytes
        img[0] = 32'h2408_0005;
        img[1] = 32'h0000_0008;
        run_image(2, 1'b0, 1'b0, -1, 1'b0);

        // Oversize header (N = 257)
        pulse_restart();
        run_image(257, 1'b0, 1'b0, -1, 1'b0);

        // Empty image
        pulse_restart();
        run_image(0, 1'b0, 1'b0, -1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_restart();
        run_image(0, 1'b0, 1'b1, -1, 1'b0);
`endif

        // Single word, with a good checksum and (when enabled) a bad one
        img[0] = 32'hDEAD_BEEF;
        pulse_restart();
        run_image(1, 1'b0, 1'b0, -1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_restart();
        run_image(1, 1'b0, 1'b1, -1, 1'b0);
`endif

        // Restart after the 2nd data byte of a gapped stream, then a full reload
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        pulse_restart();
        run_image(2, 1'b1, 1'b0, 4, 1'b0);
        run_image(3, 1'b1, 1'b0, -1, 1'b0);

        // Random small images
        repeat (6) begin
            for (int i = 0; i < 32; i++) img[i] = $urandom;
            pulse_restart();
            run_image(int'($urandom_range(24, 1)), 1'b1, 1'($urandom_range(1)), -1, 1'b0);
        end

        // Full-capacity image: first aborted by the async reset mid-word, then loaded in full
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        pulse_restart();
        run_image(256, 1'b1, 1'b0, 2 + 4 * 100 + 2, 1'b1);
        run_image(256, 1'b0, 1'b0, -1, 1'b0);

        // Largest header value
        pulse_restart();
        run_image(65535, 1'b0, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
